// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit direction counter per entry and saturating statistics.
// Lookup is combinational (zero latency); EX updates are always accepted and land on the next clk edge.
package riscv_defines;
    typedef enum logic [1:0] {
        NEXTPC_PLUS4  = 2'd0,
        NEXTPC_BRANCH = 2'd1,
        NEXTPC_JAL    = 2'd2,
        NEXTPC_JALR   = 2'd3
    } nextpc_mode_t;
endpackage

module branch_predictor
    import riscv_defines::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  nextpc_mode_t     upd_mode,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispredict,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];
    logic [CNT_W-1:0]   r_stat_br;
    logic [CNT_W-1:0]   r_stat_mis;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_acc;
    logic             w_upd_jal;
    logic             w_wr_en;
    logic [1:0]       w_new_cnt;
    logic [31:0]      w_new_target;
    logic             w_unused_pc;

    assign w_if_idx  = if_pc[IDX_W+1:2];
    assign w_if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_unused_pc = ^{if_pc, upd_pc};

    // Lookup reads only state registers; a same-cycle update is not bypassed.
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_hit    = w_if_hit;
    assign pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
    assign pred_target = w_if_hit ? r_target[w_if_idx] : 32'd0;

    assign w_upd_acc = rst_n && upd_valid &&
                       ((upd_mode == NEXTPC_BRANCH) || (upd_mode == NEXTPC_JAL));
    assign w_upd_jal = (upd_mode == NEXTPC_JAL);
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    // A not-taken branch that misses never allocates.
    assign w_wr_en   = w_upd_acc && (w_upd_hit || w_upd_jal || upd_taken);

    always_comb begin
        w_new_cnt    = r_cnt[w_upd_idx];
        w_new_target = r_target[w_upd_idx];
        if (w_upd_jal) begin
            w_new_cnt    = 2'd3;
            w_new_target = upd_target;
        end else if (!w_upd_hit) begin
            w_new_cnt    = 2'd2;
            w_new_target = upd_target;
        end else if (upd_taken) begin
            w_new_target = upd_target;
            if (r_cnt[w_upd_idx] != 2'd3) begin
                w_new_cnt = r_cnt[w_upd_idx] + 2'd1;
            end
        end else if (r_cnt[w_upd_idx] != 2'd0) begin
            w_new_cnt = r_cnt[w_upd_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= w_new_target;
            r_cnt[w_upd_idx]    <= w_new_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_wr_en) begin
                r_valid[w_upd_idx] <= 1'b1;
            end
            if (w_upd_acc && (r_stat_br != STAT_MAX)) begin
                r_stat_br <= r_stat_br + CNT_W'(1);
            end
            if (w_upd_acc && upd_mispredict && (r_stat_mis != STAT_MAX)) begin
                r_stat_mis <= r_stat_mis + CNT_W'(1);
            end
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_mispred  = r_stat_mis;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized bench for branch_predictor against an array-based reference model.
module tb_branch_predictor;
    import riscv_defines::*;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 10;
    localparam int CNT_W   = 8;
    localparam int STATMAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic [31:0]        if_pc;
    logic               pred_hit;
    logic               pred_taken;
    logic [31:0]        pred_target;
    logic               upd_valid;
    nextpc_mode_t       upd_mode;
    logic [31:0]        upd_pc;
    logic               upd_taken;
    logic [31:0]        upd_target;
    logic               upd_mispredict;
    logic [CNT_W-1:0]   stat_branches;
    logic [CNT_W-1:0]   stat_mispred;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_mode(upd_mode), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int          m_br;
    int          m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / (4 * ENTRIES)) % (1 << TAG_W);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic void m_apply(input nextpc_mode_t mode, input logic [31:0] pc,
                                    input bit taken, input logic [31:0] tgt, input bit mis);
        int  i;
        bit  hit;
        if (mode != NEXTPC_BRANCH && mode != NEXTPC_JAL) return;
        if (m_br < STATMAX) m_br++;
        if (mis && m_mis < STATMAX) m_mis++;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (mode == NEXTPC_JAL) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_cnt[i] = 3;
        end else if (hit) begin
            if (taken) begin
                m_tgt[i] = tgt;
                m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            end else begin
                m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_cnt[i] = 2;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc);
        int i;
        bit h;
        if_pc = pc;
        #1;
        i = idx_of(pc);
        h = m_valid[i] && (m_tag[i] == tag_of(pc));
        chk("pred_hit", 32'(pred_hit), 32'(h));
        chk("pred_taken", 32'(pred_taken), 32'(h && m_cnt[i] >= 2));
        chk("pred_target", pred_target, h ? m_tgt[i] : 32'd0);
    endtask

    task automatic chk_stats();
        chk("stat_branches", 32'(stat_branches), 32'(m_br));
        chk("stat_mispred", 32'(stat_mispred), 32'(m_mis));
    endtask

    task automatic drive(input bit v, input nextpc_mode_t mode, input logic [31:0] pc,
                         input bit taken, input logic [31:0] tgt, input bit mis);
        upd_valid = v; upd_mode = mode; upd_pc = pc;
        upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
    endtask

    task automatic upd(input nextpc_mode_t mode, input logic [31:0] pc,
                       input bit taken, input logic [31:0] tgt, input bit mis);
        @(negedge clk);
        drive(1'b1, mode, pc, taken, tgt, mis);
        @(posedge clk);
        m_apply(mode, pc, taken, tgt, mis);
        #1 upd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rpc();
        return ($urandom_range(0, 15) << 18) | ($urandom_range(0, 3) << 8) |
               ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nextpc_mode_t rm;
        bit           rv;
        bit           rt;
        logic [31:0]  rp;
        int           guard;

        rst_n = 1'b0;
        if_pc = 32'h100;
        drive(1'b0, NEXTPC_PLUS4, 32'h0, 1'b0, 32'h0, 1'b0);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("T1_hit", 32'(pred_hit), 32'd0);
        chk("T1_taken", 32'(pred_taken), 32'd0);
        chk("T1_target", pred_target, 32'd0);
        chk("T1_stat_br", 32'(stat_branches), 32'd0);
        chk("T1_stat_mis", 32'(stat_mispred), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T2: allocation on taken branch
        upd(NEXTPC_BRANCH, 32'h100, 1'b1, 32'h80, 1'b1);
        look(32'h100);
        chk("T2_hit", 32'(pred_hit), 32'd1);
        chk("T2_taken", 32'(pred_taken), 32'd1);
        chk("T2_target", pred_target, 32'h80);
        chk("T2_stat_br", 32'(stat_branches), 32'd1);

        // T3: counter walks down, saturates at 0, then climbs to 1
        upd(NEXTPC_BRANCH, 32'h100, 1'b0, 32'h0, 1'b1);
        upd(NEXTPC_BRANCH, 32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        chk("T3_taken_cnt0", 32'(pred_taken), 32'd0);
        upd(NEXTPC_BRANCH, 32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        upd(NEXTPC_BRANCH, 32'h100, 1'b1, 32'h84, 1'b1);
        look(32'h100);
        chk("T3_taken_cnt1", 32'(pred_taken), 32'd0);
        chk("T3_target", pred_target, 32'h84);
        chk_stats();

        // T4: aliasing JAL at same index evicts 0x100
        upd(NEXTPC_JAL, 32'h200, 1'b1, 32'h400, 1'b0);
        look(32'h100);
        chk("T4_alias_miss", 32'(pred_hit), 32'd0);
        look(32'h200);
        chk("T4_jal_taken", 32'(pred_taken), 32'd1);

        // T5: same-cycle lookup sees pre-update entry
        @(negedge clk);
        drive(1'b1, NEXTPC_BRANCH, 32'h300, 1'b1, 32'h340, 1'b0);
        look(32'h300);
        chk("T5_same_cycle_hit", 32'(pred_hit), 32'd0);
        @(posedge clk);
        m_apply(NEXTPC_BRANCH, 32'h300, 1'b1, 32'h340, 1'b0);
        #1 upd_valid = 1'b0;
        look(32'h300);
        chk("T5_next_cycle_hit", 32'(pred_hit), 32'd1);
        upd(NEXTPC_JALR, 32'h300, 1'b1, 32'h999, 1'b1);
        upd(NEXTPC_PLUS4, 32'h500, 1'b1, 32'h999, 1'b1);
        upd(NEXTPC_JALR, 32'h600, 1'b1, 32'h999, 1'b1);
        look(32'h300);
        look(32'h500);
        look(32'h600);
        chk_stats();

        // Randomized phase, including X on if_pc during updates
        for (int n = 0; n < 200; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rm = nextpc_mode_t'($urandom_range(0, 3));
            rp = rpc();
            rt = (rm == NEXTPC_JAL) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            drive(rv, rm, rp, rt, $urandom, 1'($urandom_range(0, 1)));
            if (n % 9 == 0) begin
                if_pc = 'x;
            end else begin
                look(($urandom_range(0, 1) != 0) ? rp : rpc());
            end
            @(posedge clk);
            if (rv) m_apply(rm, rp, rt, upd_target, upd_mispredict);
            #1 upd_valid = 1'b0;
            look(rpc());
            chk_stats();
        end
        look(32'h200);
        look(32'h300);

        // T6a: async reset in the middle of an update
        @(negedge clk);
        drive(1'b1, NEXTPC_JAL, 32'h700, 1'b1, 32'h70, 1'b1);
        #1 rst_n = 1'b0;
        m_reset();
        look(32'h200);
        chk("T6_reset_miss", 32'(pred_hit), 32'd0);
        look(32'h300);
        chk("T6_reset_stat_br", 32'(stat_branches), 32'd0);
        chk("T6_reset_stat_mis", 32'(stat_mispred), 32'd0);
        @(posedge clk);
        @(negedge clk);
        look(32'h700);
        chk("T6_discarded", 32'(pred_hit), 32'd0);
        drive(1'b1, NEXTPC_JAL, 32'h500, 1'b1, 32'h50, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        m_apply(NEXTPC_JAL, 32'h500, 1'b1, 32'h50, 1'b1);
        #1 upd_valid = 1'b0;
        look(32'h500);
        chk("T6_first_upd_hit", 32'(pred_hit), 32'd1);
        chk_stats();

        // T6b: drive both stats to all-ones minus one, then saturate
        guard = 0;
        while (m_br < STATMAX - 1 && guard < 400) begin
            guard++;
            upd((($urandom_range(0, 1)) != 0) ? NEXTPC_JAL : NEXTPC_BRANCH,
                rpc(), 1'($urandom_range(0, 1)), $urandom, 1'b1);
        end
        #1;
        chk("T6_br_max_m1", 32'(stat_branches), 32'(STATMAX - 1));
        chk("T6_mis_max_m1", 32'(stat_mispred), 32'(STATMAX - 1));
        for (int k = 0; k < 3; k++) upd(NEXTPC_BRANCH, rpc(), 1'b1, $urandom, 1'b1);
        #1;
        chk("T6_br_sat", 32'(stat_branches), 32'(STATMAX));
        chk("T6_mis_sat", 32'(stat_mispred), 32'(STATMAX));
        chk_stats();
        look(32'h500);

        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("T6_final_reset_br", 32'(stat_branches), 32'd0);
        chk("T6_final_reset_mis", 32'(stat_mispred), 32'd0);
        look(32'h500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
